// File: rtl/ifmap_stream_tx_if.sv
// ifmap_stream_tx_if: bundle of everything ifmap_stream_tx exchanges with its neighbours.
//   Control side : start, base_addr, row_len, num_rows in; busy, done out.
//   Memory side  : mem_ren, mem_addr out; mem_rdata in (valid 1 cycle after mem_ren).
//   Buffer side  : buf_wen, buf_din out; buf_ready in.
//   pause        : present only when IFMAP_TX_PAUSE_EN is defined.
// modport master = transmitter (DUT) view, modport slave = environment view.
interface ifmap_stream_tx_if #(
  parameter int ELEMENT_WIDTH = 16,
  parameter int ADDR_WIDTH    = 10,
  parameter int LEN_WIDTH     = 8
);
  logic                     start;
  logic [ADDR_WIDTH-1:0]    base_addr;
  logic [LEN_WIDTH-1:0]     row_len;
  logic [LEN_WIDTH-1:0]     num_rows;
  logic                     mem_ren;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [ELEMENT_WIDTH-1:0] mem_rdata;
  logic                     buf_ready;
  logic                     buf_wen;
  logic [ELEMENT_WIDTH+1:0] buf_din;
  logic                     busy;
  logic                     done;
`ifdef IFMAP_TX_PAUSE_EN
  logic                     pause;
`endif

  modport master (
`ifdef IFMAP_TX_PAUSE_EN
    input  pause,
`endif
    input  start, base_addr, row_len, num_rows, mem_rdata, buf_ready,
    output mem_ren, mem_addr, buf_wen, buf_din, busy, done
  );

  modport slave (
`ifdef IFMAP_TX_PAUSE_EN
    output pause,
`endif
    output start, base_addr, row_len, num_rows, mem_rdata, buf_ready,
    input  mem_ren, mem_addr, buf_wen, buf_din, busy, done
  );
endinterface

// File: rtl/ifmap_stream_tx.sv
// ifmap_stream_tx: walks an IFMAP region row-major out of a synchronous memory
// and writes each element into the PE input buffer as {start, end, data}.
// The start bit marks column 0 of a row and the end bit marks the last column.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active low
//   bus  - ifmap_stream_tx_if.master (config/start, memory read port,
//          buffer write port, busy/done status)
// Optional feature macro: IFMAP_TX_PAUSE_EN adds bus.pause, which holds the
// FSM in READ (with mem_ren low) for as long as it is high.
module ifmap_stream_tx #(
  parameter int ELEMENT_WIDTH = 16,
  parameter int ADDR_WIDTH    = 10,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ifmap_stream_tx_if.master     bus
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, PUSH, DONE} state_e;

  state_e                   state_q;
  logic [ADDR_WIDTH-1:0]    cur_addr_q;
  logic [LEN_WIDTH-1:0]     col_q, row_q;
  logic [LEN_WIDTH-1:0]     row_len_q, num_rows_q;
  logic [ELEMENT_WIDTH-1:0] data_q;

  logic last_col, last_row, wr, rd_go;

  // row_len_q is non-zero whenever these are used (zero sizes skip to DONE).
  assign last_col = (col_q == row_len_q - LEN_WIDTH'(1));
  assign last_row = (row_q == num_rows_q - LEN_WIDTH'(1));
  assign wr       = (state_q == PUSH) && bus.buf_ready;

`ifdef IFMAP_TX_PAUSE_EN
  assign rd_go = !bus.pause;
`else
  assign rd_go = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_len_q  <= '0;
      num_rows_q <= '0;
      data_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          cur_addr_q <= bus.base_addr;
          row_len_q  <= bus.row_len;
          num_rows_q <= bus.num_rows;
          col_q      <= '0;
          row_q      <= '0;
          state_q    <= (bus.row_len == '0 || bus.num_rows == '0) ? DONE : READ;
        end
        READ:  if (rd_go) state_q <= LATCH;
        LATCH: begin
          data_q  <= bus.mem_rdata;
          state_q <= PUSH;
        end
        PUSH: if (bus.buf_ready) begin
          cur_addr_q <= cur_addr_q + ADDR_WIDTH'(1);
          if (last_col) begin
            col_q <= '0;
            row_q <= row_q + LEN_WIDTH'(1);
          end else begin
            col_q <= col_q + LEN_WIDTH'(1);
          end
          state_q <= (last_row && last_col) ? DONE : READ;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register; buf_din is zeroed outside PUSH so the
  // reset-cleared column (col==0) does not leak a start bit.
  assign bus.mem_ren  = (state_q == READ) && rd_go;
  assign bus.mem_addr = (state_q == READ) ? cur_addr_q : '0;
  assign bus.buf_wen  = wr;
  assign bus.buf_din  = (state_q == PUSH) ? {col_q == '0, last_col, data_q} : '0;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);

endmodule
